multibyte_add_seq: RTL and testbench

//  Byte-serial multi-precision adder sequencer wrapped around simple_8bit_adder.
//  - Accepts two NUM_BYTES-wide operands one byte pair per beat, LSB first, over valid/ready.
//  - Chains each byte's cout into the next byte's cin; streams registered sum bytes downstream.
//  - Reports the final carry on the last byte. Sits between the operand source and the result sink.

---
 rtl/add_seq_pkg.sv | 15 +
 rtl/simple_8bit_adder.sv | 18 +
 rtl/multibyte_add_seq.sv | 96 +++++++++
 tb/tb_multibyte_add_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared widths, FSM encodings and the output beat layout for the byte-serial adder.
package add_seq_pkg;

   localparam int BYTE_W = 8;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   typedef struct packed {
      logic [BYTE_W-1:0] sum;
      logic              last;
      logic              cout;
   } out_beat_t;

endpackage

// File: rtl/simple_8bit_adder.sv
// Combinational byte adder: sum = (a + b + cin) mod 256, cout = bit 8 of the full sum.
module simple_8bit_adder
   import add_seq_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout
);

   logic [BYTE_W:0] full;

   assign full = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
   assign sum  = full[BYTE_W-1:0];
   assign cout = full[BYTE_W];

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial multi-precision adder, LSB first; one registered output beat, 1-cycle latency.
// Single output register without skid: in_ready = !out_valid || out_ready, and clr forces it low.
module multibyte_add_seq
   import add_seq_pkg::*;
#(
   parameter int NUM_BYTES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] in_a,
   input  logic [BYTE_W-1:0] in_b,
   input  logic              in_cin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] out_sum,
   output logic              out_last,
   output logic              out_cout,
   output logic              busy
);

   localparam int                CNT_W    = $clog2(NUM_BYTES);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_BYTES - 1);

   logic [0:0]        state;
   logic [CNT_W-1:0]  byte_cnt;
   logic              carry_q;
   out_beat_t         out_q;

   logic              accept;
   logic              last_beat;
   logic              add_cin;
   logic [BYTE_W-1:0] add_sum;
   logic              add_cout;

   assign in_ready  = !clr && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign last_beat = (byte_cnt == LAST_IDX);
   // Beat 0 always takes the external carry so nothing leaks across operations.
   assign add_cin   = (state == ST_IDLE) ? in_cin : carry_q;
   assign busy      = (state == ST_RUN) && !clr;

   assign out_sum  = out_q.sum;
   assign out_last = out_q.last;
   assign out_cout = out_q.cout;

   simple_8bit_adder u_adder (
      .a    (in_a),
      .b    (in_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         byte_cnt <= '0;
         carry_q  <= 1'b0;
      end else if (clr) begin
         state    <= ST_IDLE;
         byte_cnt <= '0;
         carry_q  <= 1'b0;
      end else if (accept) begin
         if (last_beat) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            carry_q  <= 1'b0;
         end else begin
            state    <= ST_RUN;
            byte_cnt <= byte_cnt + CNT_W'(1);
            carry_q  <= add_cout;
         end
      end
   end

   // Output register: load on accept, otherwise retire on drain and hold under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_q     <= '0;
      end else if (clr) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_q.sum  <= add_sum;
         out_q.last <= last_beat;
         out_q.cout <= last_beat ? add_cout : 1'b0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Scoreboard bench for multibyte_add_seq (NUM_BYTES=4): per-scenario tasks plus a drain monitor.
module tb_multibyte_add_seq;
   import add_seq_pkg::*;

   localparam int NB = 4;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b1;
   logic       clr       = 1'b0;
   logic       in_valid  = 1'b0;
   logic       in_ready;
   logic [7:0] in_a      = 8'h00;
   logic [7:0] in_b      = 8'h00;
   logic       in_cin    = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_sum;
   logic       out_last;
   logic       out_cout;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] sum;
      logic       last;
      logic       cout;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   multibyte_add_seq #(.NUM_BYTES(NB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_last  (out_last),
      .out_cout  (out_cout),
      .busy      (busy)
   );

   // Reference model: expected beats for the first nbeats bytes of A + B + cin.
   function automatic void push_op(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input int nbeats);
      logic [8:0] s;
      logic       c;
      exp_t       e;
      c = ci;
      for (int i = 0; i < nbeats; i++) begin
         s      = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]} + {8'h00, c};
         e.sum  = s[7:0];
         e.last = (i == NB - 1);
         e.cout = (i == NB - 1) ? s[8] : 1'b0;
         sb.push_back(e);
         c = s[8];
      end
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got sum=%h last=%b cout=%b, expected none", out_sum, out_last, out_cout);
         end else begin
            e = sb.pop_front();
            if ({out_sum, out_last, out_cout} !== {e.sum, e.last, e.cout}) begin
               n_fail++;
               $display("FAIL result_beat: got sum=%h last=%b cout=%b, expected sum=%h last=%b cout=%b",
                        out_sum, out_last, out_cout, e.sum, e.last, e.cout);
            end
         end
      end
   end

   // Hold one beat until the DUT takes it; returns just after the accepting edge.
   task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic ci);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = ci;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready stayed %b, expected 1 within 50 cycles", in_ready);
      end
   endtask

   // in_cin toggles after beat 0 to show it is ignored mid-operation.
   task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic ci);
      push_op(a, b, ci, NB);
      for (int i = 0; i < NB; i++)
         send_beat(a[8*i +: 8], b[8*i +: 8], (i == 0) ? ci : ~ci);
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      #11;
      n_checks++;
      if ({out_valid, out_sum, out_last, out_cout, busy} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b sum=%h last=%b cout=%b busy=%b, expected all 0",
                  out_valid, out_sum, out_last, out_cout, busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic;
      logic [31:0] a, b;
      a = 32'h000000FF;
      b = 32'h00000001;
      push_op(a, b, 1'b0, NB);
      for (int i = 0; i < NB; i++) begin
         send_beat(a[8*i +: 8], b[8*i +: 8], (i == 0) ? 1'b0 : 1'b1);
         if (i == 0) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== 8'h00 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL first_beat_latency: got valid=%b sum=%h busy=%b, expected 1/00/1", out_valid, out_sum, busy);
            end
         end
      end
      n_checks++;
      if (out_last !== 1'b1 || out_cout !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_last: got last=%b cout=%b busy=%b, expected 1/0/0", out_last, out_cout, busy);
      end
   endtask

   task automatic test_carry_in;
      send_op(32'hFFFFFFFF, 32'h00000000, 1'b1);
      n_checks++;
      if (out_last !== 1'b1 || out_cout !== 1'b1 || out_sum !== 8'h00) begin
         n_fail++;
         $display("FAIL carry_final: got sum=%h last=%b cout=%b, expected 00/1/1", out_sum, out_last, out_cout);
      end
   endtask

   task automatic test_back_to_back;
      send_op(32'hFFFFFFFF, 32'h00000000, 1'b1);
      push_op(32'h00000001, 32'h00000001, 1'b0, NB);
      send_beat(8'h01, 8'h01, 1'b0);
      n_checks++;
      if (out_sum !== 8'h02) begin
         n_fail++;
         $display("FAIL carry_isolation: got sum=%h, expected 02", out_sum);
      end
      for (int i = 1; i < NB; i++)
         send_beat(8'h00, 8'h00, 1'b1);
   endtask

   task automatic test_backpressure;
      push_op(32'h12345678, 32'h9ABCDEF0, 1'b1, NB);
      send_beat(8'h78, 8'hF0, 1'b1);
      send_beat(8'h56, 8'hDE, 1'b0);
      in_valid  = 1'b1;
      in_a      = 8'h34;
      in_b      = 8'hBC;
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 8'h35) begin
            n_fail++;
            $display("FAIL stall_hold: cycle %0d got in_ready=%b valid=%b sum=%h, expected 0/1/35",
                     c, in_ready, out_valid, out_sum);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_beat(8'h34, 8'hBC, 1'b0);
      send_beat(8'h12, 8'h9A, 1'b0);
   endtask

   task automatic test_clr;
      push_op(32'h000000FF, 32'h00000001, 1'b0, 2);
      send_beat(8'hFF, 8'h01, 1'b0);
      send_beat(8'h00, 8'h00, 1'b1);
      clr = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_same_cycle: got in_ready=%b busy=%b, expected 0/0", in_ready, busy);
      end
      @(posedge clk); #1;
      clr = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_after: got valid=%b busy=%b, expected 0/0", out_valid, busy);
      end
      send_op(32'h000000FF, 32'h00000001, 1'b0);
      n_checks++;
      if (out_last !== 1'b1 || out_cout !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_rerun_last: got last=%b cout=%b, expected 1/0", out_last, out_cout);
      end
   endtask

   task automatic test_reset_midop;
      push_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 2);
      send_beat(8'hFF, 8'h00, 1'b1);
      send_beat(8'hFF, 8'h00, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, out_sum, out_last, out_cout, busy} !== 12'h000) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%b sum=%h last=%b cout=%b busy=%b, expected all 0",
                  out_valid, out_sum, out_last, out_cout, busy);
      end
      n_checks++;
      if (sb.size() != 1) begin
         n_fail++;
         $display("FAIL reset_discard: got %0d pending beats, expected 1", sb.size());
      end
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_op(32'hFFFFFFFF, 32'h00000000, 1'b1);
      n_checks++;
      if (out_last !== 1'b1 || out_cout !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_rerun: got last=%b cout=%b, expected 1/1", out_last, out_cout);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry_in();
      test_back_to_back();
      test_backpressure();
      test_clr();
      test_reset_midop();
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL final_drain: got %0d pending beats valid=%b, expected 0/0", sb.size(), out_valid);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
